// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: field widths and the FIFO entry
// layout. Ifetch builds entries with the same layout.
package branch_resolver_pkg;

  localparam int unsigned PC_WIDTH    = 32;
  localparam int unsigned ENTRY_WIDTH = 2 * PC_WIDTH + 1;

  // Bit offsets inside a packed entry.
  localparam int unsigned ENTRY_ALT_LSB  = 0;
  localparam int unsigned ENTRY_PRED_BIT = PC_WIDTH;
  localparam int unsigned ENTRY_PC_LSB   = PC_WIDTH + 1;

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic                pred_taken;
    logic [PC_WIDTH-1:0] alt_pc;
  } br_entry_t;

  // A prediction was wrong when the resolved direction differs from it.
  function automatic logic is_mispredict(input br_entry_t e, input logic taken);
    return e.pred_taken != taken;
  endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Bundle of prediction, resolution and training signals around the resolver.
// master = ifetch/commit side, slave = branch_resolver.
interface branch_resolver_if #(
  parameter int unsigned DEPTH_WIDTH = 3
);

  logic                 push_valid;
  logic [31:0]          push_pc;
  logic                 push_pred_taken;
  logic [31:0]          push_alt_pc;
  logic                 push_ready;
  logic                 resolve_valid;
  logic                 resolve_taken;
  logic                 flush;
  logic                 update;
  logic [31:0]          update_pc;
  logic                 update_result;
  logic                 mispredict;
  logic [31:0]          redirect_pc;
  logic [DEPTH_WIDTH:0] count;

  modport master (
    output push_valid, push_pc, push_pred_taken, push_alt_pc,
    output resolve_valid, resolve_taken, flush,
    input  push_ready, update, update_pc, update_result,
    input  mispredict, redirect_pc, count
  );

  modport slave (
    input  push_valid, push_pc, push_pred_taken, push_alt_pc,
    input  resolve_valid, resolve_taken, flush,
    output push_ready, update, update_pc, update_result,
    output mispredict, redirect_pc, count
  );

endinterface

// File: rtl/branch_fifo.sv
// Circular FIFO of in-flight branches: storage, head/tail pointers and count.
// clear_i empties the queue and takes priority over push/pop.
module branch_fifo
  import branch_resolver_pkg::*;
#(
  parameter int unsigned DEPTH_WIDTH = 3,
  parameter int unsigned WIDTH       = ENTRY_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [WIDTH-1:0]     wdata_i,
  output logic [WIDTH-1:0]     rdata_o,
  output logic [DEPTH_WIDTH:0] count_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [DEPTH_WIDTH-1:0] head_q, head_d;
  logic [DEPTH_WIDTH-1:0] tail_q, tail_d;
  logic [DEPTH_WIDTH:0]   count_q, count_d;

  // Next pointer/count state; pointers wrap naturally at 2^DEPTH_WIDTH.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + DEPTH_WIDTH'(1);
      if (pop_i)  head_d = head_q + DEPTH_WIDTH'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + (DEPTH_WIDTH+1)'(1);
        2'b01:   count_d = count_q - (DEPTH_WIDTH+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[tail_q] <= wdata_i;
  end

  assign rdata_o = mem_q[head_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (DEPTH_WIDTH+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver: checks predictions against in-order outcomes, emits the
// predictor training stream and a one-shot mispredict redirect toward fetch.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int unsigned DEPTH_WIDTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  branch_resolver_if.slave  bus
);

  br_entry_t            head_e;
  br_entry_t            push_e;
  logic                 full, empty;
  logic                 pop_en, push_en, clear_en, mis_now;
  logic [DEPTH_WIDTH:0] fifo_count;

  logic                 update_q;
  logic [31:0]          update_pc_q;
  logic                 update_result_q;
  logic                 mispredict_q;
  logic [31:0]          redirect_pc_q;

  // Wrong-path pushes (same cycle as a mispredict or flush) are dropped;
  // the resolve itself is still evaluated before the queue is cleared.
  always_comb begin
    pop_en   = rdy && bus.resolve_valid && !empty;
    mis_now  = pop_en && is_mispredict(head_e, bus.resolve_taken);
    clear_en = rdy && (bus.flush || mis_now);
    push_en  = rdy && bus.push_valid && !full && !clear_en;
    push_e   = '{pc: bus.push_pc, pred_taken: bus.push_pred_taken,
                 alt_pc: bus.push_alt_pc};
  end

  branch_fifo #(
    .DEPTH_WIDTH (DEPTH_WIDTH),
    .WIDTH       (ENTRY_WIDTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (clear_en),
    .push_i  (push_en),
    .pop_i   (pop_en),
    .wdata_i (push_e),
    .rdata_o (head_e),
    .count_o (fifo_count),
    .full_o  (full),
    .empty_o (empty)
  );

  // Training/redirect output registers; frozen while rdy is low so a pending
  // pulse is seen by the predictor on the next enabled edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      update_q        <= 1'b0;
      update_pc_q     <= '0;
      update_result_q <= 1'b0;
      mispredict_q    <= 1'b0;
      redirect_pc_q   <= '0;
    end else if (rdy) begin
      update_q     <= pop_en;
      mispredict_q <= mis_now;
      if (pop_en) begin
        update_pc_q     <= head_e.pc;
        update_result_q <= bus.resolve_taken;
      end
      if (mis_now) redirect_pc_q <= head_e.alt_pc;
    end
  end

  assign bus.push_ready    = !full;
  assign bus.count         = fifo_count;
  assign bus.update        = update_q;
  assign bus.update_pc     = update_pc_q;
  assign bus.update_result = update_result_q;
  assign bus.mispredict    = mispredict_q;
  assign bus.redirect_pc   = redirect_pc_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed scoreboard bench for branch_resolver. Stimulus pushes expected
// training records; a negedge monitor pops and compares on each consumed update.
module tb_branch_resolver;

  typedef struct {
    logic [31:0] pc;
    logic        result;
    logic        mis;
    logic [31:0] redir;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;

  int unsigned errors = 0;
  int unsigned checks = 0;
  exp_t        exp_q[$];

  branch_resolver_if #(.DEPTH_WIDTH(3)) bus ();

  branch_resolver #(.DEPTH_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: an update is consumed on an edge where rdy is high.
  always @(negedge clk) begin
    if (rst === 1'b0 && rdy === 1'b1 && bus.update === 1'b1) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_update: got update pc=%h required no update", bus.update_pc);
      end else begin
        e = exp_q.pop_front();
        chk("update_pc", bus.update_pc, e.pc);
        chk("update_result", 32'(bus.update_result), 32'(e.result));
        chk("mispredict", 32'(bus.mispredict), 32'(e.mis));
        chk("redirect_pc", bus.redirect_pc, e.redir);
      end
    end
    if (rst === 1'b0 && bus.mispredict === 1'b1 && bus.update !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL lone_mispredict: got mispredict=1 update=%b required update=1", bus.update);
    end
  end

  task automatic idle();
    bus.push_valid      = 1'b0;
    bus.push_pc         = '0;
    bus.push_pred_taken = 1'b0;
    bus.push_alt_pc     = '0;
    bus.resolve_valid   = 1'b0;
    bus.resolve_taken   = 1'b0;
    bus.flush           = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic pv, input logic [31:0] pc, input logic pt,
                      input logic [31:0] alt, input logic rv, input logic rt,
                      input logic fl);
    bus.push_valid      = pv;
    bus.push_pc         = pc;
    bus.push_pred_taken = pt;
    bus.push_alt_pc     = alt;
    bus.resolve_valid   = rv;
    bus.resolve_taken   = rt;
    bus.flush           = fl;
    tick();
    idle();
  endtask

  task automatic push(input logic [31:0] pc, input logic pt, input logic [31:0] alt);
    step(1'b1, pc, pt, alt, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic rt);
    step(1'b0, '0, 1'b0, '0, 1'b1, rt, 1'b0);
  endtask

  task automatic expect_upd(input logic [31:0] pc, input logic res, input logic mis,
                            input logic [31:0] redir);
    exp_q.push_back('{pc: pc, result: res, mis: mis, redir: redir});
  endtask

  initial begin
    idle();
    rst = 1'b1;
    rdy = 1'b1;
    tick();
    tick();
    // Reset values
    chk("rst_update", 32'(bus.update), 32'd0);
    chk("rst_update_pc", bus.update_pc, 32'h0);
    chk("rst_update_result", 32'(bus.update_result), 32'd0);
    chk("rst_mispredict", 32'(bus.mispredict), 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_push_ready", 32'(bus.push_ready), 32'd1);
    rst = 1'b0;

    // Correct prediction
    push(32'h100, 1'b1, 32'h104);
    chk("count_after_push", 32'(bus.count), 32'd1);
    expect_upd(32'h100, 1'b1, 1'b0, 32'h0);
    resolve(1'b1);
    chk("count_after_resolve", 32'(bus.count), 32'd0);
    tick();

    // Mispredict discards the younger entry
    push(32'h200, 1'b0, 32'h240);
    push(32'h208, 1'b1, 32'h20c);
    chk("count_two", 32'(bus.count), 32'd2);
    expect_upd(32'h200, 1'b1, 1'b1, 32'h240);
    resolve(1'b1);
    chk("count_after_mispredict", 32'(bus.count), 32'd0);
    tick();
    chk("mispredict_one_shot", 32'(bus.mispredict), 32'd0);
    chk("redirect_hold", bus.redirect_pc, 32'h240);

    // Fill to capacity
    for (int i = 0; i < 8; i++) begin
      push(32'h300 + 32'(4 * i), 1'(i & 1), 32'h400 + 32'(4 * i));
      chk("fill_count", 32'(bus.count), 32'(i + 1));
    end
    chk("full_push_ready", 32'(bus.push_ready), 32'd0);
    push(32'h3fc, 1'b1, 32'h3f8);
    chk("full_push_ignored", 32'(bus.count), 32'd8);
    // Push+resolve while full: push rejected
    expect_upd(32'h300, 1'b0, 1'b0, 32'h240);
    step(1'b1, 32'h3f0, 1'b1, 32'h3f4, 1'b1, 1'b0, 1'b0);
    chk("full_push_resolve_count", 32'(bus.count), 32'd7);
    chk("push_ready_reopen", 32'(bus.push_ready), 32'd1);
    // This push lands at the wrapped tail (slot 0)
    push(32'h500, 1'b1, 32'h504);
    chk("wrap_count", 32'(bus.count), 32'd8);
    for (int i = 1; i < 8; i++) begin
      expect_upd(32'h300 + 32'(4 * i), 1'(i & 1), 1'b0, 32'h240);
      resolve(1'(i & 1));
    end
    expect_upd(32'h500, 1'b1, 1'b0, 32'h240);
    resolve(1'b1);
    chk("drain_count", 32'(bus.count), 32'd0);

    // Simultaneous push and resolve, not full
    push(32'h600, 1'b1, 32'h604);
    expect_upd(32'h600, 1'b1, 1'b0, 32'h240);
    step(1'b1, 32'h608, 1'b0, 32'h60c, 1'b1, 1'b1, 1'b0);
    chk("push_resolve_count", 32'(bus.count), 32'd1);
    expect_upd(32'h608, 1'b1, 1'b1, 32'h60c);
    resolve(1'b1);
    chk("second_mispredict_count", 32'(bus.count), 32'd0);
    tick();

    // Resolve on empty queue
    resolve(1'b1);
    chk("empty_resolve_update", 32'(bus.update), 32'd0);
    chk("empty_resolve_mispredict", 32'(bus.mispredict), 32'd0);

    // Flush with three entries plus a same-cycle push
    push(32'h700, 1'b0, 32'h780);
    push(32'h704, 1'b0, 32'h784);
    push(32'h708, 1'b0, 32'h788);
    chk("pre_flush_count", 32'(bus.count), 32'd3);
    step(1'b1, 32'h70c, 1'b0, 32'h78c, 1'b0, 1'b0, 1'b1);
    chk("flush_count", 32'(bus.count), 32'd0);

    // Flush with a same-cycle resolve still trains the predictor
    push(32'h710, 1'b1, 32'h714);
    push(32'h718, 1'b0, 32'h71c);
    expect_upd(32'h710, 1'b1, 1'b0, 32'h60c);
    step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    chk("flush_resolve_count", 32'(bus.count), 32'd0);
    tick();

    // rdy low freezes the pending update and the queue
    push(32'h800, 1'b0, 32'h840);
    expect_upd(32'h800, 1'b0, 1'b0, 32'h60c);
    step(1'b1, 32'h808, 1'b1, 32'h80c, 1'b1, 1'b0, 1'b0);
    rdy = 1'b0;
    bus.push_valid    = 1'b1;
    bus.push_pc       = 32'h900;
    bus.resolve_valid = 1'b1;
    bus.resolve_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frozen_update", 32'(bus.update), 32'd1);
      chk("frozen_count", 32'(bus.count), 32'd1);
    end
    idle();
    rdy = 1'b1;
    tick();
    chk("update_after_rdy", 32'(bus.update), 32'd0);
    chk("count_after_rdy", 32'(bus.count), 32'd1);

    // Reset overrides an in-flight (mispredicting) resolve
    push(32'h810, 1'b0, 32'h814);
    push(32'h818, 1'b0, 32'h81c);
    push(32'h820, 1'b0, 32'h824);
    chk("pre_reset_count", 32'(bus.count), 32'd4);
    rst = 1'b1;
    bus.resolve_valid = 1'b1;
    bus.resolve_taken = 1'b0;
    tick();
    rst = 1'b0;
    idle();
    chk("rst2_update", 32'(bus.update), 32'd0);
    chk("rst2_mispredict", 32'(bus.mispredict), 32'd0);
    chk("rst2_update_pc", bus.update_pc, 32'h0);
    chk("rst2_update_result", 32'(bus.update_result), 32'd0);
    chk("rst2_redirect_pc", bus.redirect_pc, 32'h0);
    chk("rst2_count", 32'(bus.count), 32'd0);
    chk("rst2_push_ready", 32'(bus.push_ready), 32'd1);
    tick();
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
